// File: rtl/stream_seq_if.sv
// Handshake bundle between job/host logic, the sequencer and the datapath.
// The master drives job control and datapath feedback; the slave is the sequencer.
interface stream_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] beats;
    logic             abort;
    logic             ready;
    logic             dp_valid;
    logic             dp_out_valid;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] returned_cnt;

    modport master (
        output start, beats, abort, ready, dp_out_valid,
        input  dp_valid, busy, done, timeout_err, issued_cnt, returned_cnt
    );

    modport slave (
        input  start, beats, abort, ready, dp_out_valid,
        output dp_valid, busy, done, timeout_err, issued_cnt, returned_cnt
    );
endinterface

// File: rtl/stream_seq_ctrl.sv
// Job sequencer for a valid-driven datapath: issues a programmed number of beats under
// ready and in-flight limits, counts returns, and flags completion or a stalled datapath.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no job; waits for start, returns are ignored
//   ST_ISSUE | issuing beats while ready and below the in-flight limit
//   ST_DRAIN | all beats issued, waiting for the remaining results
module stream_seq_ctrl #(
    parameter int CNT_W        = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    stream_seq_if.slave ctrl
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int               WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_INFLIGHT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] returned_q, returned_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;

    logic [CNT_W-1:0] inflight;
    logic             issue;
    logic             ret;

    // Limit and return qualification use registered counts only.
    assign inflight = issued_q - returned_q;
    assign issue    = (state_q == ST_ISSUE) && ctrl.ready
                      && (inflight < LIMIT) && (issued_q < target_q);
    assign ret      = (state_q != ST_IDLE) && ctrl.dp_out_valid && (inflight != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            wdog_q     <= '0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            issued_q   <= issued_d;
            returned_q <= returned_d;
            wdog_q     <= wdog_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        issued_d   = issued_q;
        returned_d = returned_q;
        wdog_d     = wdog_q;
        done_d     = 1'b0;
        terr_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (ctrl.start && !ctrl.abort) begin
                    issued_d   = '0;
                    returned_d = '0;
                    if (ctrl.beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = ctrl.beats;
                        state_d  = ST_ISSUE;
                    end
                end
            end
            default: begin
                // Abort beats the watchdog, which beats normal completion; counters hold.
                if (ctrl.abort) begin
                    state_d = ST_IDLE;
                end else if ((inflight != '0) && !ctrl.dp_out_valid && (wdog_q == WD_LAST)) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    issued_d   = issued_q + CNT_W'(issue);
                    returned_d = returned_q + CNT_W'(ret);
                    wdog_d     = ((inflight == '0) || ctrl.dp_out_valid) ? '0
                                 : wdog_q + WD_W'(1);
                    if ((state_q == ST_ISSUE) && (issued_d == target_q)) begin
                        state_d = ST_DRAIN;
                    end
                    if ((state_q == ST_DRAIN) && (returned_d == target_q)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    assign ctrl.dp_valid     = issue;
    assign ctrl.busy         = (state_q != ST_IDLE);
    assign ctrl.done         = done_q;
    assign ctrl.timeout_err  = terr_q;
    assign ctrl.issued_cnt   = issued_q;
    assign ctrl.returned_cnt = returned_q;
endmodule

// File: tb/tb_stream_seq_ctrl.sv
// Bench for stream_seq_ctrl: a fixed-latency datapath model plus a job-level reference
// model of the sequencer, compared every cycle against the DUT outputs.
module tb_stream_seq_ctrl;
    localparam int CNT_W = 8;
    localparam int MAXF  = 4;
    localparam int TMO   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stream_seq_if #(.CNT_W(CNT_W)) bus ();

    stream_seq_ctrl #(
        .CNT_W       (CNT_W),
        .MAX_INFLIGHT(MAXF),
        .TIMEOUT     (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;

    // Datapath model: each issued beat returns lat cycles later, ret_left limits returns.
    int  due[$];
    int  lat     = 3;
    int  ret_left = -1;
    bit  rnd_ov  = 1'b0;

    // Job-level reference model.
    bit             m_act, m_done, m_terr, exp_dv;
    logic [CNT_W-1:0] m_tgt, m_iss, m_ret;
    int             m_quiet;

    logic [19:0] obs_v, exp_v;

    task automatic model_reset();
        m_act = 0; m_done = 0; m_terr = 0; exp_dv = 0;
        m_tgt = '0; m_iss = '0; m_ret = '0; m_quiet = 0;
        due.delete();
    endtask

    task automatic new_test(input int latency, input int returns);
        due.delete();
        lat = latency;
        ret_left = returns;
        rnd_ov = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.beats = '0;
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic settle();
        bit ov;
        logic [CNT_W-1:0] infl;
        ov = 1'b0;
        while (due.size() > 0 && due[0] < cyc_no) void'(due.pop_front());
        if (due.size() > 0 && due[0] == cyc_no) begin
            void'(due.pop_front());
            if (ret_left != 0) begin
                ov = 1'b1;
                if (ret_left > 0) ret_left--;
            end
        end
        bus.dp_out_valid = ov | rnd_ov;
        #1;
        infl   = m_iss - m_ret;
        exp_dv = m_act && bus.ready && (infl < CNT_W'(MAXF)) && (m_iss < m_tgt);
        obs_v  = {bus.dp_valid, bus.busy, bus.done, bus.timeout_err, bus.issued_cnt, bus.returned_cnt};
        exp_v  = {exp_dv, m_act, m_done, m_terr, m_iss, m_ret};
    endtask

    task automatic advance();
        logic [CNT_W-1:0] infl;
        bit ov;
        infl = m_iss - m_ret;
        ov   = bus.dp_out_valid;
        if (exp_dv) due.push_back(cyc_no + lat);
        @(posedge clk);
        m_done = 0;
        m_terr = 0;
        if (bus.abort) begin
            m_act = 0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_iss = '0; m_ret = '0; m_quiet = 0;
                if (bus.beats == '0) m_done = 1;
                else begin m_act = 1; m_tgt = bus.beats; end
            end
        end else if (infl != '0 && !ov && m_quiet == TMO - 1) begin
            m_act  = 0;
            m_terr = 1;
        end else begin
            if (exp_dv) m_iss = m_iss + 1'b1;
            if (ov && infl != '0) m_ret = m_ret + 1'b1;
            m_quiet = (infl == '0 || ov) ? 0 : m_quiet + 1;
            if (m_ret == m_tgt) begin m_act = 0; m_done = 1; end
        end
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.dp_valid, bus.busy, bus.done, bus.timeout_err, bus.issued_cnt, bus.returned_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset: got %h want 00000",
                     {bus.dp_valid, bus.busy, bus.done, bus.timeout_err, bus.issued_cnt, bus.returned_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        new_test(3, -1);
        bus.ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd5;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL basic cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 0 && !m_act && !m_done) break;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.issued_cnt !== 8'd5 || bus.returned_cnt !== 8'd5) begin
            errors++;
            $display("FAIL basic_end: got busy=%b iss=%0d ret=%0d want 0/5/5", bus.busy, bus.issued_cnt, bus.returned_cnt);
        end
    endtask

    task automatic test_inflight_limit();
        int peak;
        logic [CNT_W-1:0] fl;
        peak = 0;
        new_test(10, -1);
        bus.ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd6;
            settle();
            fl = bus.issued_cnt - bus.returned_cnt;
            if (int'(fl) > peak) peak = int'(fl);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL limit cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 0 && !m_act && !m_done) break;
        end
        checks++;
        if (peak != MAXF || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL limit_peak: got peak=%0d busy=%b want %0d/0", peak, bus.busy, MAXF);
        end
    endtask

    task automatic test_ready_toggle();
        new_test(2, -1);
        for (int c = 0; c < 100; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd4;
            bus.ready = (c % 2 == 1);
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL ready cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            if (c == 8) begin
                checks++;
                if (bus.issued_cnt !== 8'd4) begin errors++; $display("FAIL ready_cnt: got %0d want 4", bus.issued_cnt); end
            end
            advance();
            if (c > 8 && !m_act && !m_done) break;
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_timeout();
        bit saw_terr, saw_done;
        saw_terr = 0; saw_done = 0;
        new_test(3, 1);
        bus.ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd3;
            settle();
            if (bus.timeout_err === 1'b1) saw_terr = 1;
            if (bus.done === 1'b1) saw_done = 1;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL timeout cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 0 && !m_act && !m_done && !m_terr) break;
        end
        checks++;
        if (!saw_terr || saw_done || bus.busy !== 1'b0 || bus.returned_cnt !== 8'd1) begin
            errors++;
            $display("FAIL timeout_end: got terr=%0d done=%0d busy=%b ret=%0d want 1/0/0/1",
                     saw_terr, saw_done, bus.busy, bus.returned_cnt);
        end
    endtask

    task automatic test_abort();
        new_test(20, -1);
        for (int c = 0; c < 40; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd8;
            bus.abort = m_act && (m_iss == 8'd2);
            bus.ready = !bus.abort;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL abort cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.issued_cnt !== 8'd2 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: got busy=%b iss=%0d done=%b want 0/2/0", bus.busy, bus.issued_cnt, bus.done);
        end
        bus.abort = 1'b0;
        bus.ready = 1'b1;
    endtask

    task automatic test_reset_mid_job();
        new_test(3, -1);
        bus.ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd8;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL rstjob cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dp_valid, bus.busy, bus.done, bus.timeout_err, bus.issued_cnt, bus.returned_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL rstjob_async: got %h want 00000",
                     {bus.dp_valid, bus.busy, bus.done, bus.timeout_err, bus.issued_cnt, bus.returned_cnt});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_and_restart();
        new_test(4, -1);
        bus.ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'd0;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL zero cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 0 && !m_act && !m_done) break;
        end
        for (int c = 0; c < 100; c++) begin
            bus.start = (c == 0) || (c == 3) || (c == 6);
            bus.beats = (c == 0) ? 8'd6 : 8'd2;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL restart cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 6 && !m_act && !m_done) break;
        end
        checks++;
        if (bus.issued_cnt !== 8'd6 || bus.returned_cnt !== 8'd6) begin
            errors++;
            $display("FAIL restart_end: got iss=%0d ret=%0d want 6/6", bus.issued_cnt, bus.returned_cnt);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            int b;
            b = $urandom_range(30, 1);
            new_test($urandom_range(8, 1), -1);
            for (int c = 0; c < 400; c++) begin
                bus.start = (c == 0);
                bus.beats = CNT_W'(b);
                bus.ready = ($urandom_range(3) != 0);
                rnd_ov    = ($urandom_range(9) == 0);
                settle();
                checks++;
                if (obs_v !== exp_v) begin errors++; $display("FAIL random job %0d cyc %0d: got %h want %h", j, cyc_no, obs_v, exp_v); end
                advance();
                if (c > 0 && !m_act && !m_done && !m_terr) break;
            end
            rnd_ov = 1'b0;
            checks++;
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL random_budget job %0d: got busy=%b want 0", j, bus.busy); end
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_max_beats();
        new_test(2, -1);
        bus.ready = 1'b1;
        for (int c = 0; c < 600; c++) begin
            bus.start = (c == 0);
            bus.beats = 8'hFF;
            settle();
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL maxbeats cyc %0d: got %h want %h", cyc_no, obs_v, exp_v); end
            advance();
            if (c > 0 && !m_act && !m_done) break;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.issued_cnt !== 8'hFF || bus.returned_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL maxbeats_end: got busy=%b iss=%0d ret=%0d want 0/255/255", bus.busy, bus.issued_cnt, bus.returned_cnt);
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.beats        = '0;
        bus.abort        = 1'b0;
        bus.ready        = 1'b0;
        bus.dp_out_valid = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_inflight_limit();
        test_ready_toggle();
        test_timeout();
        test_abort();
        test_reset_mid_job();
        test_zero_and_restart();
        test_random();
        test_max_beats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench time limit expired");
    end
endmodule
